// File: rtl/rs_issue_sched_if.sv
// Rename/wakeup/FU-side signal bundle of the reservation-station scheduler.
// master drives dispatch, wakeup, busy and flush; slave is the scheduler itself.
interface rs_issue_sched_if;
  logic       flush;
  logic       disp_valid_1, disp_valid_2;
  logic [6:0] disp_op_1, disp_op_2;
  logic [5:0] disp_pd_1, disp_ps1_1, disp_ps2_1;
  logic [5:0] disp_pd_2, disp_ps1_2, disp_ps2_2;
  logic       disp_ps1_rdy_1, disp_ps2_rdy_1, disp_ps1_rdy_2, disp_ps2_rdy_2;
  logic [1:0] disp_fu_1, disp_fu_2;
  logic [3:0] disp_rob_1, disp_rob_2;
  logic       disp_ready;
  logic       wk_valid_1, wk_valid_2;
  logic [5:0] wk_tag_1, wk_tag_2;
  logic [2:0] fu_busy;
  logic       iss_valid_0, iss_valid_1, iss_valid_2;
  logic [6:0] iss_op_0, iss_op_1, iss_op_2;
  logic [5:0] iss_pd_0, iss_pd_1, iss_pd_2;
  logic [5:0] iss_ps1_0, iss_ps1_1, iss_ps1_2;
  logic [5:0] iss_ps2_0, iss_ps2_1, iss_ps2_2;
  logic [3:0] iss_rob_0, iss_rob_1, iss_rob_2;
  logic [4:0] occupancy;
  logic       bad_fu;

  modport master (
    output flush, disp_valid_1, disp_valid_2, disp_op_1, disp_op_2,
           disp_pd_1, disp_ps1_1, disp_ps2_1, disp_pd_2, disp_ps1_2, disp_ps2_2,
           disp_ps1_rdy_1, disp_ps2_rdy_1, disp_ps1_rdy_2, disp_ps2_rdy_2,
           disp_fu_1, disp_fu_2, disp_rob_1, disp_rob_2,
           wk_valid_1, wk_valid_2, wk_tag_1, wk_tag_2, fu_busy,
    input  disp_ready, iss_valid_0, iss_valid_1, iss_valid_2,
           iss_op_0, iss_op_1, iss_op_2, iss_pd_0, iss_pd_1, iss_pd_2,
           iss_ps1_0, iss_ps1_1, iss_ps1_2, iss_ps2_0, iss_ps2_1, iss_ps2_2,
           iss_rob_0, iss_rob_1, iss_rob_2, occupancy, bad_fu
  );

  modport slave (
    input  flush, disp_valid_1, disp_valid_2, disp_op_1, disp_op_2,
           disp_pd_1, disp_ps1_1, disp_ps2_1, disp_pd_2, disp_ps1_2, disp_ps2_2,
           disp_ps1_rdy_1, disp_ps2_rdy_1, disp_ps1_rdy_2, disp_ps2_rdy_2,
           disp_fu_1, disp_fu_2, disp_rob_1, disp_rob_2,
           wk_valid_1, wk_valid_2, wk_tag_1, wk_tag_2, fu_busy,
    output disp_ready, iss_valid_0, iss_valid_1, iss_valid_2,
           iss_op_0, iss_op_1, iss_op_2, iss_pd_0, iss_pd_1, iss_pd_2,
           iss_ps1_0, iss_ps1_1, iss_ps1_2, iss_ps2_0, iss_ps2_1, iss_ps2_2,
           iss_rob_0, iss_rob_1, iss_rob_2, occupancy, bad_fu
  );
endinterface

// File: rtl/rs_issue_sched.sv
// 16-row reservation station: 2-wide dispatch, 2-bus wakeup, and oldest-ready
// select per functional unit using an age matrix.
module rs_issue_sched #(
  parameter int ENTRIES = 16,
  parameter int NUM_FU  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rs_issue_sched_if.slave bus
);
  localparam int OCC_W = $clog2(ENTRIES) + 1;

  typedef struct packed {
    logic [6:0] op;
    logic [5:0] pd;
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic [1:0] fu;
    logic [3:0] rob;
  } row_t;

  typedef struct packed {
    logic [6:0] op;
    logic [5:0] pd;
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic [3:0] rob;
  } iss_t;

  // Tag 0 is the hardwired-ready register; a matching wakeup bypasses in.
  function automatic logic src_ready(input logic [5:0] tag, input logic rdy,
                                     input logic v1, input logic [5:0] t1,
                                     input logic v2, input logic [5:0] t2);
    return rdy || (tag == 6'd0) || (v1 && (tag == t1)) || (v2 && (tag == t2));
  endfunction

  row_t               row_p0 [ENTRIES];
  logic [ENTRIES-1:0] in_use_p0, r1_p0, r2_p0;
  logic [ENTRIES-1:0] age_p0 [ENTRIES];
  logic [OCC_W-1:0]   occ_p0;
  logic               disp_ready_p0, bad_p0;
  logic [NUM_FU-1:0]  vld_p1;
  iss_t               iss_p1 [NUM_FU];

  row_t               ln_row [2];
  logic [1:0]         ln_vld, ln_r1, ln_r2, do_l, bad_l;
  logic               accept;
  logic [ENTRIES-1:0] free_v, free2, a1, a2;
  logic [ENTRIES-1:0] older [ENTRIES];
  logic [ENTRIES-1:0] elig [NUM_FU];
  logic [ENTRIES-1:0] sel [NUM_FU];
  logic [ENTRIES-1:0] iss_mask, in_use_n, r1_n, r2_n;
  logic [ENTRIES-1:0] age_n [ENTRIES];
  logic [NUM_FU-1:0]  vld_n;
  iss_t               iss_n [NUM_FU];
  logic [OCC_W-1:0]   n_iss, n_alloc, occ_n;
  logic               dr_n;

  // ---- stage p0 inputs: dispatch lanes and row allocation ----
  always_comb begin
    ln_vld[0] = bus.disp_valid_1;
    ln_vld[1] = bus.disp_valid_2;
    ln_row[0] = '{op: bus.disp_op_1, pd: bus.disp_pd_1, ps1: bus.disp_ps1_1,
                  ps2: bus.disp_ps2_1, fu: bus.disp_fu_1, rob: bus.disp_rob_1};
    ln_row[1] = '{op: bus.disp_op_2, pd: bus.disp_pd_2, ps1: bus.disp_ps1_2,
                  ps2: bus.disp_ps2_2, fu: bus.disp_fu_2, rob: bus.disp_rob_2};
    ln_r1[0] = src_ready(bus.disp_ps1_1, bus.disp_ps1_rdy_1, bus.wk_valid_1,
                         bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2);
    ln_r2[0] = src_ready(bus.disp_ps2_1, bus.disp_ps2_rdy_1, bus.wk_valid_1,
                         bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2);
    ln_r1[1] = src_ready(bus.disp_ps1_2, bus.disp_ps1_rdy_2, bus.wk_valid_1,
                         bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2);
    ln_r2[1] = src_ready(bus.disp_ps2_2, bus.disp_ps2_rdy_2, bus.wk_valid_1,
                         bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2);

    // disp_ready guarantees two free rows, so both one-hot picks always hit
    accept = disp_ready_p0 & ~bus.flush;
    for (int k = 0; k < 2; k++) begin
      do_l[k]  = accept & ln_vld[k] & (ln_row[k].fu != 2'd3);
      bad_l[k] = accept & ln_vld[k] & (ln_row[k].fu == 2'd3);
    end
    free_v = ~in_use_p0;
    a1     = do_l[0] ? (free_v & (~free_v + ENTRIES'(1))) : '0;
    free2  = free_v & ~a1;
    a2     = do_l[1] ? (free2 & (~free2 + ENTRIES'(1))) : '0;
  end

  // ---- stage p0 select: oldest ready row per FU ----
  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        older[i][j] = age_p0[j][i];
    iss_mask = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < ENTRIES; i++)
        elig[f][i] = in_use_p0[i] & r1_p0[i] & r2_p0[i] & ~bus.flush &
                     (row_p0[i].fu == 2'(f)) & ~bus.fu_busy[f];
      for (int i = 0; i < ENTRIES; i++)
        sel[f][i] = elig[f][i] & ~|(elig[f] & older[i]);
      iss_mask = iss_mask | sel[f];
    end
  end

  always_comb begin
    n_iss = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      vld_n[f] = |sel[f];
      iss_n[f] = iss_p1[f];
      for (int i = 0; i < ENTRIES; i++)
        if (sel[f][i])
          iss_n[f] = '{op: row_p0[i].op, pd: row_p0[i].pd, ps1: row_p0[i].ps1,
                       ps2: row_p0[i].ps2, rob: row_p0[i].rob};
      n_iss = n_iss + OCC_W'(vld_n[f]);
    end
  end

  // ---- next row state: wakeup, allocation, age and occupancy ----
  always_comb begin
    in_use_n = bus.flush ? '0 : ((in_use_p0 & ~iss_mask) | a1 | a2);
    for (int i = 0; i < ENTRIES; i++) begin
      r1_n[i] = a1[i] ? ln_r1[0] : a2[i] ? ln_r1[1] :
                (r1_p0[i] | src_ready(row_p0[i].ps1, 1'b0, bus.wk_valid_1,
                                      bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2));
      r2_n[i] = a1[i] ? ln_r2[0] : a2[i] ? ln_r2[1] :
                (r2_p0[i] | src_ready(row_p0[i].ps2, 1'b0, bus.wk_valid_1,
                                      bus.wk_tag_1, bus.wk_valid_2, bus.wk_tag_2));
    end
    // a new row is younger than every resident row; lane 1 beats lane 2
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++) begin
        age_n[i][j] = age_p0[i][j];
        if (bus.flush)                age_n[i][j] = 1'b0;
        else if (a1[i])               age_n[i][j] = a2[j];
        else if (a2[i])               age_n[i][j] = 1'b0;
        else if (a1[j] | a2[j])       age_n[i][j] = in_use_p0[i];
      end
    n_alloc = OCC_W'(do_l[0]) + OCC_W'(do_l[1]);
    occ_n   = bus.flush ? '0 : (occ_p0 + n_alloc - n_iss);
    dr_n    = (occ_n <= OCC_W'(ENTRIES - 2));
  end

  // ---- stage p0 -> p1 registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_use_p0     <= '0;
      r1_p0         <= '0;
      r2_p0         <= '0;
      for (int i = 0; i < ENTRIES; i++) age_p0[i] <= '0;
      occ_p0        <= '0;
      disp_ready_p0 <= 1'b1;
      bad_p0        <= 1'b0;
      vld_p1        <= '0;
      for (int f = 0; f < NUM_FU; f++) iss_p1[f] <= '0;
    end else begin
      in_use_p0     <= in_use_n;
      r1_p0         <= r1_n;
      r2_p0         <= r2_n;
      for (int i = 0; i < ENTRIES; i++) age_p0[i] <= age_n[i];
      occ_p0        <= occ_n;
      disp_ready_p0 <= dr_n;
      bad_p0        <= bad_p0 | (|bad_l);
      vld_p1        <= vld_n;
      for (int f = 0; f < NUM_FU; f++) iss_p1[f] <= iss_n[f];
    end
  end

  // Row payload is only meaningful while in_use is set, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (a1[i])      row_p0[i] <= ln_row[0];
      else if (a2[i]) row_p0[i] <= ln_row[1];
    end
  end

  assign bus.disp_ready  = disp_ready_p0;
  assign bus.occupancy   = occ_p0;
  assign bus.bad_fu      = bad_p0;
  assign bus.iss_valid_0 = vld_p1[0];
  assign bus.iss_valid_1 = vld_p1[1];
  assign bus.iss_valid_2 = vld_p1[2];
  assign bus.iss_op_0    = iss_p1[0].op;
  assign bus.iss_op_1    = iss_p1[1].op;
  assign bus.iss_op_2    = iss_p1[2].op;
  assign bus.iss_pd_0    = iss_p1[0].pd;
  assign bus.iss_pd_1    = iss_p1[1].pd;
  assign bus.iss_pd_2    = iss_p1[2].pd;
  assign bus.iss_ps1_0   = iss_p1[0].ps1;
  assign bus.iss_ps1_1   = iss_p1[1].ps1;
  assign bus.iss_ps1_2   = iss_p1[2].ps1;
  assign bus.iss_ps2_0   = iss_p1[0].ps2;
  assign bus.iss_ps2_1   = iss_p1[1].ps2;
  assign bus.iss_ps2_2   = iss_p1[2].ps2;
  assign bus.iss_rob_0   = iss_p1[0].rob;
  assign bus.iss_rob_1   = iss_p1[1].rob;
  assign bus.iss_rob_2   = iss_p1[2].rob;
endmodule

// File: tb/tb_rs_issue_sched.sv
// Scoreboard bench for rs_issue_sched: an age-ordered queue model predicts every
// post-edge output; a monitor compares the DUT against those predictions.
module tb_rs_issue_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_issue_sched_if u_if();
  rs_issue_sched #(.ENTRIES(16), .NUM_FU(3)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

  typedef struct packed {
    logic [6:0] op; logic [5:0] pd; logic [5:0] ps1; logic r1;
    logic [5:0] ps2; logic r2; logic [1:0] fu; logic [3:0] rob;
  } ent_t;
  typedef struct packed {
    logic [6:0] op; logic [5:0] pd; logic [5:0] ps1; logic [5:0] ps2; logic [3:0] rob;
  } iss_t;
  typedef struct packed {
    logic [2:0] vld; iss_t [2:0] fld; logic [4:0] occ; logic dr; logic bad;
  } exp_t;

  ent_t       m_q[$];     // resident instructions, oldest first
  iss_t [2:0] m_last;
  logic       m_bad;
  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  function automatic logic hit(logic [5:0] tag);
    return (u_if.wk_valid_1 && u_if.wk_tag_1 == tag) || (u_if.wk_valid_2 && u_if.wk_tag_2 == tag);
  endfunction

  function automatic ent_t mk(logic [6:0] op, logic [5:0] pd, logic [5:0] ps1, logic rd1,
                              logic [5:0] ps2, logic rd2, logic [1:0] fu, logic [3:0] rob);
    ent_t e;
    e.op = op; e.pd = pd; e.ps1 = ps1; e.ps2 = ps2; e.fu = fu; e.rob = rob;
    e.r1 = rd1 || (ps1 == 6'd0) || hit(ps1);
    e.r2 = rd2 || (ps2 == 6'd0) || hit(ps2);
    return e;
  endfunction

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    exp_t e;
    ent_t nq[$];
    ent_t t;
    int   pick[3];
    bit   dr_now;
    e = '0;
    if (!rst_n) begin
      m_q.delete(); m_last = '0; m_bad = 1'b0;
    end else if (u_if.flush) begin
      m_q.delete();
    end else begin
      dr_now = (m_q.size() <= 14);
      for (int f = 0; f < 3; f++) begin
        pick[f] = -1;
        if (!u_if.fu_busy[f])
          for (int i = 0; i < m_q.size(); i++)
            if (pick[f] < 0 && m_q[i].fu == 2'(f) && m_q[i].r1 && m_q[i].r2) pick[f] = i;
        if (pick[f] >= 0) begin
          t = m_q[pick[f]];
          e.vld[f] = 1'b1;
          m_last[f] = {t.op, t.pd, t.ps1, t.ps2, t.rob};
        end
      end
      for (int i = 0; i < m_q.size(); i++)
        if (i != pick[0] && i != pick[1] && i != pick[2]) begin
          t = m_q[i];
          if (hit(t.ps1)) t.r1 = 1'b1;
          if (hit(t.ps2)) t.r2 = 1'b1;
          nq.push_back(t);
        end
      if (dr_now) begin
        if (u_if.disp_valid_1) begin
          if (u_if.disp_fu_1 == 2'd3) m_bad = 1'b1;
          else nq.push_back(mk(u_if.disp_op_1, u_if.disp_pd_1, u_if.disp_ps1_1, u_if.disp_ps1_rdy_1,
                               u_if.disp_ps2_1, u_if.disp_ps2_rdy_1, u_if.disp_fu_1, u_if.disp_rob_1));
        end
        if (u_if.disp_valid_2) begin
          if (u_if.disp_fu_2 == 2'd3) m_bad = 1'b1;
          else nq.push_back(mk(u_if.disp_op_2, u_if.disp_pd_2, u_if.disp_ps1_2, u_if.disp_ps1_rdy_2,
                               u_if.disp_ps2_2, u_if.disp_ps2_rdy_2, u_if.disp_fu_2, u_if.disp_rob_2));
        end
      end
      m_q = nq;
    end
    e.fld = m_last;
    e.occ = 5'(m_q.size());
    e.dr  = (m_q.size() <= 14);
    e.bad = m_bad;
    sb_q.push_back(e);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    u_if.flush = 1'b0; u_if.fu_busy = 3'b000;
    u_if.disp_valid_1 = 1'b0; u_if.disp_valid_2 = 1'b0;
    u_if.wk_valid_1 = 1'b0; u_if.wk_valid_2 = 1'b0;
    u_if.wk_tag_1 = 6'd0; u_if.wk_tag_2 = 6'd0;
  endtask

  task automatic lane(int k, logic [6:0] op, logic [5:0] pd, logic [5:0] ps1, logic rd1,
                      logic [5:0] ps2, logic rd2, logic [1:0] fu, logic [3:0] rob);
    if (k == 1) begin
      u_if.disp_valid_1 = 1'b1; u_if.disp_op_1 = op; u_if.disp_pd_1 = pd;
      u_if.disp_ps1_1 = ps1; u_if.disp_ps1_rdy_1 = rd1; u_if.disp_ps2_1 = ps2;
      u_if.disp_ps2_rdy_1 = rd2; u_if.disp_fu_1 = fu; u_if.disp_rob_1 = rob;
    end else begin
      u_if.disp_valid_2 = 1'b1; u_if.disp_op_2 = op; u_if.disp_pd_2 = pd;
      u_if.disp_ps1_2 = ps1; u_if.disp_ps1_rdy_2 = rd1; u_if.disp_ps2_2 = ps2;
      u_if.disp_ps2_rdy_2 = rd2; u_if.disp_fu_2 = fu; u_if.disp_rob_2 = rob;
    end
  endtask

  task automatic check_reset_now();
    chk("rst_iss_valid", 64'({u_if.iss_valid_2, u_if.iss_valid_1, u_if.iss_valid_0}), 64'(0));
    chk("rst_iss_fields", 64'({u_if.iss_op_0, u_if.iss_pd_1, u_if.iss_ps1_2, u_if.iss_ps2_0, u_if.iss_rob_1}), 64'(0));
    chk("rst_occupancy", 64'(u_if.occupancy), 64'(0));
    chk("rst_disp_ready", 64'(u_if.disp_ready), 64'(1));
    chk("rst_bad_fu", 64'(u_if.bad_fu), 64'(0));
  endtask

  // Monitor: one prediction per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    iss_t [2:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act[0] = {u_if.iss_op_0, u_if.iss_pd_0, u_if.iss_ps1_0, u_if.iss_ps2_0, u_if.iss_rob_0};
        act[1] = {u_if.iss_op_1, u_if.iss_pd_1, u_if.iss_ps1_1, u_if.iss_ps2_1, u_if.iss_rob_1};
        act[2] = {u_if.iss_op_2, u_if.iss_pd_2, u_if.iss_ps1_2, u_if.iss_ps2_2, u_if.iss_rob_2};
        chk("iss_valid_0", 64'(u_if.iss_valid_0), 64'(e.vld[0]));
        chk("iss_valid_1", 64'(u_if.iss_valid_1), 64'(e.vld[1]));
        chk("iss_valid_2", 64'(u_if.iss_valid_2), 64'(e.vld[2]));
        for (int f = 0; f < 3; f++) chk($sformatf("iss_fields_%0d", f), 64'(act[f]), 64'(e.fld[f]));
        chk("occupancy", 64'(u_if.occupancy), 64'(e.occ));
        chk("disp_ready", 64'(u_if.disp_ready), 64'(e.dr));
        chk("bad_fu", 64'(u_if.bad_fu), 64'(e.bad));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [1:0] fu;
    idle();
    lane(1, 0, 0, 0, 0, 0, 0, 0, 0); lane(2, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(3);
    rst_n = 1'b1;
    step(1);

    // basic ready dispatch to FU0
    lane(1, 7'h33, 6'd33, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 4'd0); step(1);
    idle(); step(2);

    // unready source woken three cycles later
    lane(1, 7'h11, 6'd40, 6'd35, 1'b0, 6'd2, 1'b1, 2'd1, 4'd1); step(1);
    idle(); step(3);
    u_if.wk_valid_1 = 1'b1; u_if.wk_tag_1 = 6'd35; step(1);
    idle(); step(3);

    // age order under a busy FU
    u_if.fu_busy = 3'b100;
    lane(1, 7'h21, 6'd41, 6'd1, 1'b1, 6'd2, 1'b1, 2'd2, 4'd3);
    lane(2, 7'h22, 6'd42, 6'd1, 1'b1, 6'd2, 1'b1, 2'd2, 4'd4); step(1);
    u_if.disp_valid_1 = 1'b0; u_if.disp_valid_2 = 1'b0; step(1);
    idle(); step(3);

    // fill to 15 rows, then attempt more while full
    for (int c = 0; c < 7; c++) begin
      lane(1, 7'(c), 6'(50 + c), 6'(10 + 2 * c), 1'b0, 6'd0, 1'b0, 2'd0, 4'(c));
      lane(2, 7'(c + 8), 6'(58 + c), 6'(11 + 2 * c), 1'b0, 6'd0, 1'b0, 2'd0, 4'(c + 8));
      step(1);
    end
    idle(); lane(1, 7'h7f, 6'd63, 6'd24, 1'b0, 6'd0, 1'b0, 2'd0, 4'd15); step(1);
    lane(1, 7'h55, 6'd45, 6'd1, 1'b1, 6'd2, 1'b1, 2'd1, 4'd5);
    lane(2, 7'h56, 6'd46, 6'd1, 1'b1, 6'd2, 1'b1, 2'd1, 4'd6); step(2);
    idle(); u_if.wk_valid_2 = 1'b1; u_if.wk_tag_2 = 6'd10; step(1);
    idle(); step(3);

    // same-cycle wakeup bypass and tag-0 source
    lane(1, 7'h44, 6'd47, 6'd1, 1'b1, 6'd44, 1'b0, 2'd1, 4'd7);
    u_if.wk_valid_2 = 1'b1; u_if.wk_tag_2 = 6'd44; step(1);
    idle(); lane(1, 7'h45, 6'd48, 6'd0, 1'b0, 6'd3, 1'b1, 2'd2, 4'd8); step(1);
    idle(); step(2);

    // illegal FU index, then flush with rows resident
    lane(1, 7'h66, 6'd49, 6'd1, 1'b1, 6'd2, 1'b1, 2'd3, 4'd9); step(1);
    idle(); u_if.flush = 1'b1; u_if.wk_valid_1 = 1'b1; u_if.wk_tag_1 = 6'd11;
    lane(1, 7'h67, 6'd50, 6'd1, 1'b1, 6'd2, 1'b1, 2'd0, 4'd10); step(1);
    idle(); step(2);
    for (int c = 0; c < 5; c++) begin
      lane(1, 7'(c), 6'(20 + c), 6'(30 + c), 1'b0, 6'd0, 1'b0, 2'(c % 3), 4'(c));
      lane(2, 7'(c), 6'(25 + c), 6'(36 + c), 1'b0, 6'd0, 1'b0, 2'(c % 3), 4'(c + 5));
      step(1);
    end
    idle(); u_if.flush = 1'b1; step(1);
    idle(); step(2);

    // randomized traffic with a mid-stream asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        idle();
        rst_n = 1'b0;
        #1;
        check_reset_now();
        step(2);
        rst_n = 1'b1;
        continue;
      end
      idle();
      for (int k = 1; k <= 2; k++)
        if ($urandom_range(0, 1) == 1) begin
          fu = ($urandom_range(0, 40) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          lane(k, 7'($urandom), 6'($urandom), 6'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               6'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), fu, 4'($urandom));
        end
      u_if.wk_valid_1 = ($urandom_range(0, 2) == 0); u_if.wk_tag_1 = 6'($urandom_range(0, 15));
      u_if.wk_valid_2 = ($urandom_range(0, 2) == 0); u_if.wk_tag_2 = 6'($urandom_range(0, 15));
      u_if.fu_busy = (c > 200 && c < 320) ? 3'($urandom | 3'b011) : 3'($urandom & $urandom);
      u_if.flush = ($urandom_range(0, 120) == 0);
      step(1);
    end
    idle();
    step(2);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
